// File: rtl/dbus_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Master indices
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Transfer-size encodings carried on *_bmul
  localparam logic [1:0] BMUL_BYTE = 2'b00;
  localparam logic [1:0] BMUL_HALF = 2'b01;
  localparam logic [1:0] BMUL_WORD = 2'b10;

  // Read-latency bound and the width of the latency down-counter
  localparam int unsigned RD_LAT_MAX = 3;
  localparam int unsigned CNT_W      = 2;

  // Counter preload for a given read latency, clamped into 1..RD_LAT_MAX
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned rd_lat);
    int unsigned lat;
    lat = rd_lat;
    if (lat < 32'd1)      lat = 32'd1;
    if (lat > RD_LAT_MAX) lat = RD_LAT_MAX;
    return CNT_W'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick; the last-winner pointer lives in the parent.
module arb_rr2
  import dbus_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic [1:0] i_mask,
  output logic       o_gnt_idx_c,
  output logic       o_gnt_vld_c
);

  logic [1:0] w_req;

  assign w_req = i_req & ~i_mask;

  // A lone requester wins; on a tie the master not served last wins
  always_comb begin
    o_gnt_vld_c = |w_req;
    o_gnt_idx_c = M0;
    if (w_req == 2'b11) begin
      o_gnt_idx_c = ~i_last;
    end else if (w_req[1]) begin
      o_gnt_idx_c = M1;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (core M0, debug monitor M1), single-slave data-bus arbiter.
// Single-beat reads/writes, one outstanding transaction, fixed read latency.
// Optional DBUS_ARB_LOCK_EN adds m1_lock, which blocks M0 grants while high.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          n_rst,
`ifdef DBUS_ARB_LOCK_EN
  input  logic          m1_lock,
`endif
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [1:0]    m0_bmul,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [1:0]    m1_bmul,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_r_en,
  output logic [AW-1:0] bus_r_addr,
  output logic [1:0]    bus_r_bmul,
  input  logic [DW-1:0] bus_r_data,
  output logic          bus_w_en,
  output logic [AW-1:0] bus_w_addr,
  output logic [DW-1:0] bus_w_data,
  output logic [1:0]    bus_w_bmul,
  output logic          arb_busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(RD_LAT);

  // State and latched transaction context
  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_win;
  logic             r_we;

  // Registered outputs
  logic [1:0]       r_ack;
  logic [DW-1:0]    r_rdata [2];
  logic             r_r_en;
  logic [AW-1:0]    r_r_addr;
  logic [1:0]       r_r_bmul;
  logic             r_w_en;
  logic [AW-1:0]    r_w_addr;
  logic [DW-1:0]    r_w_data;
  logic [1:0]       r_w_bmul;
  logic             r_busy;

  // Next-state / next-output wires
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_nxt;
  logic             w_lat;
  logic [1:0]       w_ack_nxt;
  logic [1:0]       w_rd_ld;
  logic             w_r_en_nxt;
  logic [AW-1:0]    w_r_addr_nxt;
  logic [1:0]       w_r_bmul_nxt;
  logic             w_w_en_nxt;
  logic [AW-1:0]    w_w_addr_nxt;
  logic [DW-1:0]    w_w_data_nxt;
  logic [1:0]       w_w_bmul_nxt;

  // Arbitration and winner field select
  logic             w_gnt_idx;
  logic             w_gnt_vld;
  logic [1:0]       w_mask;
  logic             w_sel_we;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic [1:0]       w_sel_bmul;

`ifdef DBUS_ARB_LOCK_EN
  assign w_mask = {1'b0, m1_lock};
`else
  assign w_mask = 2'b00;
`endif

  arb_rr2 u_rr2 (
    .i_req       ({m1_req, m0_req}),
    .i_last      (r_last),
    .i_mask      (w_mask),
    .o_gnt_idx_c (w_gnt_idx),
    .o_gnt_vld_c (w_gnt_vld)
  );

  assign w_sel_we    = (w_gnt_idx == M1) ? m1_we    : m0_we;
  assign w_sel_addr  = (w_gnt_idx == M1) ? m1_addr  : m0_addr;
  assign w_sel_wdata = (w_gnt_idx == M1) ? m1_wdata : m0_wdata;
  assign w_sel_bmul  = (w_gnt_idx == M1) ? m1_bmul  : m0_bmul;

  // Next state and next registered outputs; bus fields are loaded at the grant
  // so the output registers double as the latched address/data/bmul
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_lat        = 1'b0;
    w_ack_nxt    = 2'b00;
    w_rd_ld      = 2'b00;
    w_r_en_nxt   = 1'b0;
    w_r_addr_nxt = '0;
    w_r_bmul_nxt = 2'b00;
    w_w_en_nxt   = 1'b0;
    w_w_addr_nxt = '0;
    w_w_data_nxt = '0;
    w_w_bmul_nxt = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = ST_ISSUE;
          w_last_nxt  = w_gnt_idx;
          w_lat       = 1'b1;
          if (w_sel_we) begin
            w_w_en_nxt           = 1'b1;
            w_w_addr_nxt         = w_sel_addr;
            w_w_data_nxt         = w_sel_wdata;
            w_w_bmul_nxt         = w_sel_bmul;
            w_ack_nxt[w_gnt_idx] = 1'b1;
          end else begin
            w_r_en_nxt   = 1'b1;
            w_r_addr_nxt = w_sel_addr;
            w_r_bmul_nxt = w_sel_bmul;
          end
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt      = ST_DONE;
          w_ack_nxt[r_win] = 1'b1;
          w_rd_ld[r_win]   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, context and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= M1;
      r_win      <= M0;
      r_we       <= 1'b0;
      r_ack      <= 2'b00;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_r_en     <= 1'b0;
      r_r_addr   <= '0;
      r_r_bmul   <= 2'b00;
      r_w_en     <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_w_bmul   <= 2'b00;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      if (w_lat) begin
        r_win <= w_gnt_idx;
        r_we  <= w_sel_we;
      end
      r_ack    <= w_ack_nxt;
      if (w_rd_ld[0]) r_rdata[0] <= bus_r_data;
      if (w_rd_ld[1]) r_rdata[1] <= bus_r_data;
      r_r_en   <= w_r_en_nxt;
      r_r_addr <= w_r_addr_nxt;
      r_r_bmul <= w_r_bmul_nxt;
      r_w_en   <= w_w_en_nxt;
      r_w_addr <= w_w_addr_nxt;
      r_w_data <= w_w_data_nxt;
      r_w_bmul <= w_w_bmul_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign m0_ack     = r_ack[0];
  assign m1_ack     = r_ack[1];
  assign m0_rdata   = r_rdata[0];
  assign m1_rdata   = r_rdata[1];
  assign bus_r_en   = r_r_en;
  assign bus_r_addr = r_r_addr;
  assign bus_r_bmul = r_r_bmul;
  assign bus_w_en   = r_w_en;
  assign bus_w_addr = r_w_addr;
  assign bus_w_data = r_w_data;
  assign bus_w_bmul = r_w_bmul;
  assign arb_busy   = r_busy;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: sequencer queues expected bus/ack events,
// a negedge monitor pops and checks them as the DUT presents enables and acks.
module tb_dbus_arbiter;
  import dbus_arb_pkg::*;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  bmul;
    logic [31:0] rdata;
    int          req_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        m_req   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_bmul  [2];
`ifdef DBUS_ARB_LOCK_EN
  logic        m1_lock;
`endif
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_r_en, bus_w_en, arb_busy;
  logic [31:0] bus_r_addr, bus_r_data, bus_w_addr, bus_w_data;
  logic [1:0]  bus_r_bmul, bus_w_bmul;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_ack [2];
  exp_t q_exp [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_arbiter #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
`ifdef DBUS_ARB_LOCK_EN
    .m1_lock    (m1_lock),
`endif
    .m0_req     (m_req[0]),
    .m0_we      (m_we[0]),
    .m0_addr    (m_addr[0]),
    .m0_wdata   (m_wdata[0]),
    .m0_bmul    (m_bmul[0]),
    .m0_ack     (m0_ack),
    .m0_rdata   (m0_rdata),
    .m1_req     (m_req[1]),
    .m1_we      (m_we[1]),
    .m1_addr    (m_addr[1]),
    .m1_wdata   (m_wdata[1]),
    .m1_bmul    (m_bmul[1]),
    .m1_ack     (m1_ack),
    .m1_rdata   (m1_rdata),
    .bus_r_en   (bus_r_en),
    .bus_r_addr (bus_r_addr),
    .bus_r_bmul (bus_r_bmul),
    .bus_r_data (bus_r_data),
    .bus_w_en   (bus_w_en),
    .bus_w_addr (bus_w_addr),
    .bus_w_data (bus_w_data),
    .bus_w_bmul (bus_w_bmul),
    .arb_busy   (arb_busy)
  );

  // Slave read contents: 0x10 reads 0x000000A5, other addresses scrambled
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return 32'h0000_00A5 ^ ((a - 32'h10) * 32'h9E37_79B9);
  endfunction

  // Slave read pipeline: data valid for exactly one cycle, RD_LAT cycles after bus_r_en
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bus_r_en ? rd_fn(bus_r_addr) : 32'hBAD0_0000;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus_r_data = rd_pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 1) ? m1_ack : m0_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic push(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] b, input logic [31:0] rd, input int rc);
    exp_t e;
    e.m = m; e.we = we; e.addr = a; e.wdata = d; e.bmul = b; e.rdata = rd; e.req_cyc = rc;
    q_exp.push_back(e);
  endtask

  // Wait (bounded) for master m's ack, then return just after the edge ending it
  task automatic wait_ack(input int m);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (ack_of(m)) got = 1'b1;
    end
    if (!got) chk($sformatf("ack_timeout_m%0d", m), {31'b0, ack_of(m)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int m, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] b);
    m_we[m] = we; m_addr[m] = a; m_wdata[m] = d; m_bmul[m] = b; m_req[m] = 1'b1;
    wait_ack(m);
    m_req[m] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m0_ack"},   {31'b0, m0_ack},   32'd0);
    chk({tag, "_m1_ack"},   {31'b0, m1_ack},   32'd0);
    chk({tag, "_r_en"},     {31'b0, bus_r_en}, 32'd0);
    chk({tag, "_w_en"},     {31'b0, bus_w_en}, 32'd0);
    chk({tag, "_busy"},     {31'b0, arb_busy}, 32'd0);
    chk({tag, "_bus_flds"}, bus_r_addr | bus_w_addr | bus_w_data
                            | {28'b0, bus_r_bmul, bus_w_bmul}, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  // Monitor: pops expectations on every enable; matches read acks to the pending read
  exp_t e_mon;
  exp_t pend;
  bit   pend_v = 1'b0;
  int   pend_cyc;
  always @(negedge clk) begin
    if (!n_rst) begin
      pend_v = 1'b0;
    end else begin
      if (bus_r_en && bus_w_en) chk("two_enables", {30'b0, bus_r_en, bus_w_en}, 32'd1);
      if (m0_ack && m1_ack)     chk("two_acks",    {30'b0, m1_ack, m0_ack},     32'd1);
      if (bus_r_en || bus_w_en) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_en", {30'b0, bus_r_en, bus_w_en}, 32'd0);
        end else begin
          e_mon = q_exp.pop_front();
          chk("busy_in_issue", {31'b0, arb_busy}, 32'd1);
          chk("direction", {31'b0, bus_w_en}, {31'b0, e_mon.we});
          if (e_mon.req_cyc >= 0) chk("issue_lat", cyc, e_mon.req_cyc + 1);
          if (e_mon.we) begin
            chk("w_addr", bus_w_addr, e_mon.addr);
            chk("w_data", bus_w_data, e_mon.wdata);
            chk("w_bmul", {30'b0, bus_w_bmul}, {30'b0, e_mon.bmul});
            chk("w_ack_winner", {30'b0, m1_ack, m0_ack}, (e_mon.m == 1) ? 32'd2 : 32'd1);
            if (m0_ack) n_ack[0]++;
            if (m1_ack) n_ack[1]++;
          end else begin
            chk("r_addr", bus_r_addr, e_mon.addr);
            chk("r_bmul", {30'b0, bus_r_bmul}, {30'b0, e_mon.bmul});
            chk("r_no_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
            pend = e_mon; pend_v = 1'b1; pend_cyc = cyc;
          end
        end
      end else begin
        chk("idle_bus_flds", bus_r_addr | bus_w_addr | bus_w_data
                             | {28'b0, bus_r_bmul, bus_w_bmul}, 32'd0);
        if (m0_ack || m1_ack) begin
          if (!pend_v) begin
            chk("unexpected_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
          end else begin
            chk("rd_ack_winner", {30'b0, m1_ack, m0_ack}, (pend.m == 1) ? 32'd2 : 32'd1);
            chk("rd_ack_lat", cyc, pend_cyc + RD_LAT + 1);
            chk("rd_data", rdata_of(pend.m), pend.rdata);
            if (m0_ack) n_ack[0]++;
            if (m1_ack) n_ack[1]++;
            pend_v = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  int a0, a1;
  initial begin
    n_ack[0] = 0; n_ack[1] = 0;
    n_rst = 1'b0;
`ifdef DBUS_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0; m_bmul[m] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // M0 word write; ack in the ISSUE cycle, IDLE right after
    push(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, BMUL_WORD, 32'h0, cyc);
    drive(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, BMUL_WORD);
    chk("idle_after_write", {31'b0, arb_busy}, 32'd0);

    // M1 read of 0x10 returns 0xA5 RD_LAT+2 cycles after the request edge
    push(1, 1'b0, 32'h10, 32'h0, BMUL_WORD, 32'h0000_00A5, cyc);
    drive(1, 1'b0, 32'h10, 32'h0, BMUL_WORD);
    chk("m1_rdata_after_read", m1_rdata, 32'h0000_00A5);

    // Both masters stream writes: grants alternate starting with M0
    a0 = n_ack[0]; a1 = n_ack[1];
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b1, 32'h100 + 32'(i * 8), 32'hA000_0000 + 32'(i), BMUL_WORD, 32'h0, -1);
      push(1, 1'b1, 32'h200 + 32'(i * 8), 32'hB000_0000 + 32'(i), BMUL_HALF, 32'h0, -1);
    end
    fork
      for (int i = 0; i < 6; i++) drive(0, 1'b1, 32'h100 + 32'(i * 8), 32'hA000_0000 + 32'(i), BMUL_WORD);
      for (int i = 0; i < 6; i++) drive(1, 1'b1, 32'h200 + 32'(i * 8), 32'hB000_0000 + 32'(i), BMUL_HALF);
    join
    chk("stream_m0_acks", 32'(n_ack[0] - a0), 32'd6);
    chk("stream_m1_acks", 32'(n_ack[1] - a1), 32'd6);
    chk("m1_rdata_hold", m1_rdata, 32'h0000_00A5);

    // Reset during WAIT of an M0 read: abandoned, then the held request completes
    push(0, 1'b0, 32'h80, 32'h0, BMUL_WORD, rd_fn(32'h80), cyc);
    push(0, 1'b0, 32'h80, 32'h0, BMUL_WORD, rd_fn(32'h80), -1);
    m_we[0] = 1'b0; m_addr[0] = 32'h80; m_bmul[0] = BMUL_WORD; m_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    n_rst = 1'b1;
    wait_ack(0);
    m_req[0] = 1'b0;
    chk("m0_rdata_after_retry", m0_rdata, rd_fn(32'h80));

    // Fresh reset, then contended mixed traffic: M0 wins the first tie
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    push(0, 1'b0, 32'h40, 32'h0,         BMUL_BYTE, rd_fn(32'h40), -1);
    push(1, 1'b1, 32'h50, 32'h5555_AAAA, BMUL_HALF, 32'h0,         -1);
    push(0, 1'b1, 32'h70, 32'h7070_0707, BMUL_WORD, 32'h0,         -1);
    push(1, 1'b0, 32'h60, 32'h0,         BMUL_HALF, rd_fn(32'h60), -1);
    fork
      begin
        drive(0, 1'b0, 32'h40, 32'h0,         BMUL_BYTE);
        drive(0, 1'b1, 32'h70, 32'h7070_0707, BMUL_WORD);
      end
      begin
        drive(1, 1'b1, 32'h50, 32'h5555_AAAA, BMUL_HALF);
        drive(1, 1'b0, 32'h60, 32'h0,         BMUL_HALF);
      end
    join
    chk("m0_rdata_mixed", m0_rdata, rd_fn(32'h40));
    chk("m1_rdata_mixed", m1_rdata, rd_fn(32'h60));

`ifdef DBUS_ARB_LOCK_EN
    // Lock: only M1 served while held; M0 goes once the lock drops
    m1_lock = 1'b1;
    push(1, 1'b1, 32'hA0, 32'h1111_0000, BMUL_WORD, 32'h0, -1);
    push(1, 1'b1, 32'hA4, 32'h1111_0001, BMUL_WORD, 32'h0, -1);
    push(1, 1'b1, 32'hA8, 32'h1111_0002, BMUL_WORD, 32'h0, -1);
    push(0, 1'b1, 32'h90, 32'h2222_0000, BMUL_WORD, 32'h0, -1);
    fork
      drive(0, 1'b1, 32'h90, 32'h2222_0000, BMUL_WORD);
      begin
        drive(1, 1'b1, 32'hA0, 32'h1111_0000, BMUL_WORD);
        drive(1, 1'b1, 32'hA4, 32'h1111_0001, BMUL_WORD);
        drive(1, 1'b1, 32'hA8, 32'h1111_0002, BMUL_WORD);
        repeat (4) @(posedge clk);
        #1;
        chk("lock_m0_held", 32'(q_exp.size()), 32'd1);
        m1_lock = 1'b0;
      end
    join
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q_exp.size()), 32'd0);
    chk("no_pending_read", {31'b0, pend_v}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
